// File: rtl/jam_search.sv
// jam_search: exhaustive job-assignment search engine for N workers and N jobs.
// Walks all N! worker-to-job permutations in lexicographic order. For each
// permutation it queries the external cost table once per job (W/J out,
// Cost in, same cycle), then in one EVAL cycle folds the total into the
// running minimum and the count of permutations that reach it.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   start      run request, sampled only in IDLE
//   W, J       worker / job index of the current cost query (registered)
//   Cost       cost of worker W on job J, supplied combinationally
//   MinCost    minimum total cost found (registered)
//   MatchCount number of permutations whose total equals MinCost (registered)
//   Valid      one-cycle end-of-run pulse
//   Busy       high from start accept through the Valid cycle
//
// state | meaning
// IDLE  | waiting for start, results held
// QUERY | one cycle per job k, accumulating Cost
// EVAL  | compare total with minimum, step to next permutation
// DONE  | Valid pulse, then back to IDLE
module jam_search #(
  parameter  int N   = 8,
  parameter  int CW  = 7,
  parameter  int MCW = 16,
  localparam int IW  = (N > 1) ? $clog2(N) : 1,
  localparam int SW  = CW + IW
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  output logic [IW-1:0]  W,
  output logic [IW-1:0]  J,
  input  logic [CW-1:0]  Cost,
  output logic [SW-1:0]  MinCost,
  output logic [MCW-1:0] MatchCount,
  output logic           Valid,
  output logic           Busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] QUERY = 2'd1;
  localparam logic [1:0] EVAL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] perm [N];
  logic [IW-1:0] nxt  [N];
  logic [IW-1:0] k;
  logic [SW-1:0] acc;
  logic          is_last;
  logic [IW-1:0] w_next;
  logic [IW-1:0] pv;
  logic [IW-1:0] pm;
  int            piv;
  int            mi;

  // Lexicographic successor. All array accesses use loop constants and
  // compare against the computed position, so no variable-index muxes are
  // written by hand. piv < 0 means perm is already the descending (final) one.
  always_comb begin
    piv = -1;
    mi  = 0;
    pv  = '0;
    pm  = '0;
    for (int i = 0; i < N - 1; i++)
      if (perm[i] < perm[i+1]) piv = i;
    is_last = (piv < 0);
    for (int i = 0; i < N; i++)
      if (i == piv) pv = perm[i];
    for (int m = 0; m < N; m++)
      if (m > piv && perm[m] > pv) mi = m;
    for (int i = 0; i < N; i++)
      if (i == mi) pm = perm[i];
    for (int t = 0; t < N; t++) begin
      nxt[t] = perm[t];
      if (t == piv) begin
        nxt[t] = pm;
      end else if (t > piv) begin
        // tail is reversed: position t takes the element from N+piv-t,
        // where the slot mi already holds the old pivot after the swap
        for (int s = 0; s < N; s++)
          if (s == N + piv - t) nxt[t] = (s == mi) ? pv : perm[s];
      end
    end
    w_next = '0;
    for (int t = 0; t < N; t++)
      if (IW'(t) == k + 1'b1) w_next = perm[t];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      W          <= '0;
      J          <= '0;
      k          <= '0;
      acc        <= '0;
      MinCost    <= '1;
      MatchCount <= '0;
      Valid      <= 1'b0;
      Busy       <= 1'b0;
      for (int i = 0; i < N; i++) perm[i] <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
            k          <= '0;
            acc        <= '0;
            MinCost    <= '1;
            MatchCount <= '0;
            W          <= '0;
            J          <= '0;
            Busy       <= 1'b1;
            state      <= QUERY;
          end
        end
        QUERY: begin
          acc <= acc + {{IW{1'b0}}, Cost};
          if (k == IW'(N - 1)) begin
            state <= EVAL;
          end else begin
            k <= k + 1'b1;
            W <= w_next;
            J <= k + 1'b1;
          end
        end
        EVAL: begin
          if (acc < MinCost) begin
            MinCost    <= acc;
            MatchCount <= MCW'(1);
          end else if (acc == MinCost) begin
            MatchCount <= MatchCount + 1'b1;
          end
          acc <= '0;
          k   <= '0;
          if (is_last) begin
            Valid <= 1'b1;
            state <= DONE;
          end else begin
            for (int i = 0; i < N; i++) perm[i] <= nxt[i];
            W     <= nxt[0];
            J     <= '0;
            state <= QUERY;
          end
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_search.sv
// tb_jam_search: randomized self-checking bench for jam_search at N=4.
// The reference enumerates every 4-digit base-4 tuple in counting order and
// keeps the ones with distinct digits, which is the lexicographic permutation
// list; totals, minimum and tie count come from plain arithmetic over it.
module tb_jam_search;

  localparam int N      = 4;
  localparam int CW     = 7;
  localparam int MCW    = 16;
  localparam int IW     = 2;
  localparam int SW     = 9;
  localparam int NF     = 24;
  localparam int RUNLEN = NF * (N + 1);

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic [IW-1:0]  W;
  logic [IW-1:0]  J;
  logic [CW-1:0]  Cost;
  logic [SW-1:0]  MinCost;
  logic [MCW-1:0] MatchCount;
  logic           Valid;
  logic           Busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int plist [NF][N];
  logic [CW-1:0] cost_tbl [N][N];
  int exp_min;
  int exp_cnt;

  jam_search #(.N(N), .CW(CW), .MCW(MCW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .W(W), .J(J), .Cost(Cost),
    .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  assign Cost = cost_tbl[W][J];

  always @(negedge CLK) if (Valid === 1'b1) n_valid++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_perms();
    int cnt;
    int d [N];
    bit dup;
    cnt = 0;
    for (int code = 0; code < N ** N; code++) begin
      for (int j = 0; j < N; j++) d[j] = (code / (N ** (N - 1 - j))) % N;
      dup = 1'b0;
      for (int a = 0; a < N; a++)
        for (int b = a + 1; b < N; b++)
          if (d[a] == d[b]) dup = 1'b1;
      if (!dup) begin
        for (int j = 0; j < N; j++) plist[cnt][j] = d[j];
        cnt++;
      end
    end
  endtask

  task automatic fill_tbl(input int mode);
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++)
        case (mode)
          0:       cost_tbl[w][j] = CW'($urandom_range(0, 127));
          1:       cost_tbl[w][j] = CW'($urandom_range(0, 3));
          2:       cost_tbl[w][j] = CW'((w > j) ? w - j : j - w);
          default: cost_tbl[w][j] = CW'(127);
        endcase
  endtask

  task automatic model();
    int s;
    exp_min = 32'h7fffffff;
    exp_cnt = 0;
    for (int p = 0; p < NF; p++) begin
      s = 0;
      for (int j = 0; j < N; j++) s += int'(cost_tbl[plist[p][j]][j]);
      if (s < exp_min) begin
        exp_min = s;
        exp_cnt = 1;
      end else if (s == exp_min) begin
        exp_cnt++;
      end
    end
  endtask

  // One full run; poke pulses start during QUERY and during DONE.
  task automatic run_check(input bit poke);
    int p, r, v0;
    model();
    v0 = n_valid;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int cyc = 0; cyc <= RUNLEN + 2; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (cyc == 0) begin
        chk("init_min", 32'(MinCost), 32'h1ff);
        chk("init_cnt", 32'(MatchCount), 0);
      end
      if (cyc < RUNLEN) begin
        p = cyc / (N + 1);
        r = cyc % (N + 1);
        if (r < N) begin
          chk("query_w", 32'(W), 32'(plist[p][r]));
          chk("query_j", 32'(J), 32'(r));
        end else begin
          chk("run_busy", 32'(Busy), 1);
          chk("run_valid", 32'(Valid), 0);
        end
      end
      if (poke && cyc == 7) start = 1'b1;
      if (poke && cyc == 8) start = 1'b0;
      if (cyc == RUNLEN) begin
        chk("done_valid", 32'(Valid), 1);
        chk("done_busy", 32'(Busy), 1);
        chk("min_cost", 32'(MinCost), 32'(exp_min));
        chk("match_count", 32'(MatchCount), 32'(exp_cnt));
        if (poke) start = 1'b1;
      end
      if (cyc == RUNLEN + 1) begin
        start = 1'b0;
        chk("idle_valid", 32'(Valid), 0);
        chk("idle_busy", 32'(Busy), 0);
      end
      if (cyc == RUNLEN + 2) begin
        chk("hold_busy", 32'(Busy), 0);
        chk("hold_min", 32'(MinCost), 32'(exp_min));
        chk("hold_cnt", 32'(MatchCount), 32'(exp_cnt));
      end
    end
    chk("valid_pulses", 32'(n_valid - v0), 1);
  endtask

  task automatic rst_mid();
    int v0;
    v0 = n_valid;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    repeat (13) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_w", 32'(W), 0);
    chk("rst_j", 32'(J), 0);
    chk("rst_min", 32'(MinCost), 32'h1ff);
    chk("rst_cnt", 32'(MatchCount), 0);
    chk("rst_valid", 32'(Valid), 0);
    chk("rst_busy", 32'(Busy), 0);
    @(negedge CLK) RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("post_rst_busy", 32'(Busy), 0);
    chk("aborted_valid", 32'(n_valid - v0), 0);
  endtask

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    build_perms();
    fill_tbl(2);
    #1;
    chk("reset_w", 32'(W), 0);
    chk("reset_j", 32'(J), 0);
    chk("reset_min", 32'(MinCost), 32'h1ff);
    chk("reset_cnt", 32'(MatchCount), 0);
    chk("reset_valid", 32'(Valid), 0);
    chk("reset_busy", 32'(Busy), 0);
    @(negedge CLK);
    @(negedge CLK) RST = 1'b0;

    run_check(1'b0);
    run_check(1'b0);
    fill_tbl(3);
    run_check(1'b1);
    for (int i = 0; i < 6; i++) begin
      fill_tbl(i % 2);
      run_check(i[0]);
    end
    fill_tbl(0);
    rst_mid();
    run_check(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
